// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single-port data BRAM between the core load/store path and the
// read-only inspection port. One access is in flight at a time. The BRAM read
// latency is absorbed in WAIT, and the requester that issued the access gets a
// one-cycle acknowledge together with registered read data.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | no access in flight; arbitrate and latch the winner's request
// S_ISSUE | drive the BRAM enable/write-enable with the latched address/data
// S_WAIT  | count down the BRAM read latency, then capture the read data
// S_RESP  | pulse the winner's acknowledge; requests are not sampled here
module dmem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [31:0]       i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack,
    output logic              o_cpu_stall,
    input  logic              i_dbg_req,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_dbg_ack,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_lat_cnt;
    logic                r_win_dbg;
    logic                r_prio_dbg;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;

    logic                w_latch;
    logic                w_grant_dbg;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic                w_capture;
    logic                w_unused;

    // Byte offset and address bits above the BRAM range are ignored (word access).
    assign w_unused = ^{i_cpu_addr[31:ADDR_W+2], i_cpu_addr[1:0]};

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, arbitration and BRAM/ack strobes decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_grant_dbg = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_capture   = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_cpu_ack   = 1'b0;
        o_dbg_ack   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cpu_req || i_dbg_req) begin
                    w_latch     = 1'b1;
                    // Under contention the side that was not granted last wins.
                    w_grant_dbg = i_dbg_req && (!i_cpu_req || r_prio_dbg);
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_mem_en = 1'b1;
                o_mem_we = r_we;
                if (r_we) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_load  = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_RESP: begin
                o_cpu_ack   = !r_win_dbg;
                o_dbg_ack   = r_win_dbg;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch, round-robin pointer, latency counter and read-data capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lat_cnt   <= '0;
            r_win_dbg   <= 1'b0;
            r_prio_dbg  <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (w_latch) begin
                r_win_dbg  <= w_grant_dbg;
                r_prio_dbg <= !w_grant_dbg;
                r_addr     <= w_grant_dbg ? i_dbg_addr : i_cpu_addr[ADDR_W+1:2];
                r_we       <= !w_grant_dbg && i_cpu_we;
                r_wdata    <= w_grant_dbg ? '0 : i_cpu_wdata;
            end
            if (w_cnt_load) begin
                r_lat_cnt <= CNT_W'(READ_LAT - 1);
            end else if (w_cnt_dec) begin
                r_lat_cnt <= r_lat_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                if (r_win_dbg) begin
                    r_dbg_rdata <= i_mem_rdata;
                end else begin
                    r_cpu_rdata <= i_mem_rdata;
                end
            end
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_dbg_rdata = r_dbg_rdata;
    assign o_cpu_stall = i_cpu_req & ~o_cpu_ack;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a READ_LAT=1 instance driven by directed and
// random request patterns, plus a READ_LAT=3 instance for latency checks.
// Each attached BRAM is a simple behavioural memory with a read pipeline.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LAT    = 1;
    localparam int LAT3   = 3;

    typedef struct packed {
        logic        is_dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic              cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dbg_req, dbg_ack;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic              c3_req, c3_we, c3_ack, c3_stall;
    logic [31:0]       c3_addr;
    logic [DATA_W-1:0] c3_wdata, c3_rdata;
    logic              d3_req, d3_ack;
    logic [ADDR_W-1:0] d3_addr;
    logic [DATA_W-1:0] d3_rdata;
    logic              m3_en, m3_we;
    logic [ADDR_W-1:0] m3_addr;
    logic [DATA_W-1:0] m3_wdata, m3_rdata;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(LAT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
        .o_cpu_stall(cpu_stall),
        .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .o_dbg_rdata(dbg_rdata),
        .o_dbg_ack(dbg_ack),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(LAT3)) dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(c3_req), .i_cpu_we(c3_we), .i_cpu_addr(c3_addr),
        .i_cpu_wdata(c3_wdata), .o_cpu_rdata(c3_rdata), .o_cpu_ack(c3_ack),
        .o_cpu_stall(c3_stall),
        .i_dbg_req(d3_req), .i_dbg_addr(d3_addr), .o_dbg_rdata(d3_rdata),
        .o_dbg_ack(d3_ack),
        .o_mem_en(m3_en), .o_mem_we(m3_we), .o_mem_addr(m3_addr),
        .o_mem_wdata(m3_wdata), .i_mem_rdata(m3_rdata)
    );

    // Power-up memory contents, a fixed hash of the word address.
    function automatic logic [31:0] init_val(input int a);
        return 32'((32'h9E37_79B9 * (a + 1)) ^ 32'h5A5A_0000);
    endfunction

    // Behavioural BRAM for the READ_LAT=1 instance.
    logic [31:0] bram   [1024];
    bit          bram_v [1024];
    logic [31:0] bpipe  [LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            bram[mem_addr]   <= mem_wdata;
            bram_v[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we)
            bpipe[0] <= bram_v[mem_addr] ? bram[mem_addr] : init_val(int'(mem_addr));
        for (int i = 1; i < LAT; i++) bpipe[i] <= bpipe[i-1];
    end
    assign mem_rdata = bpipe[LAT-1];

    // Behavioural BRAM for the READ_LAT=3 instance.
    logic [31:0] bram3   [1024];
    bit          bram3_v [1024];
    logic [31:0] bpipe3  [LAT3];
    always @(posedge clk) begin
        if (m3_en && m3_we) begin
            bram3[m3_addr]   <= m3_wdata;
            bram3_v[m3_addr] <= 1'b1;
        end
        if (m3_en && !m3_we)
            bpipe3[0] <= bram3_v[m3_addr] ? bram3[m3_addr] : init_val(int'(m3_addr));
        for (int i = 1; i < LAT3; i++) bpipe3[i] <= bpipe3[i-1];
    end
    assign m3_rdata = bpipe3[LAT3-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: memory contents, round-robin memory, held read data.
    logic [31:0] ref_mem [int];
    bit          last_dbg   = 1'b1;
    logic [31:0] cpu_rd_exp = '0;
    logic [31:0] dbg_rd_exp = '0;

    // Current round description.
    txn_t ct [2];
    txn_t dt;
    int   ncpu;
    bit   has_dbg;
    bit   drop_early;

    function automatic int word_of(input txn_t t);
        return t.is_dbg ? int'(t.addr[ADDR_W-1:0]) : int'(t.addr[ADDR_W+1:2]);
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
    endfunction

    function automatic txn_t mk_cpu(input bit we, input int w, input logic [31:0] d);
        txn_t t;
        t.is_dbg = 1'b0;
        t.we     = we;
        t.addr   = ($urandom & 32'hFFFF_F003) | (32'(w) << 2);
        t.wdata  = d;
        return t;
    endfunction

    function automatic txn_t mk_dbg(input int w);
        txn_t t;
        t.is_dbg = 1'b1;
        t.we     = 1'b0;
        t.addr   = 32'(w);
        t.wdata  = '0;
        return t;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_cpu_ack", cpu_ack, 0);
        check_val("rst_dbg_ack", dbg_ack, 0);
        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        check_val("rst_cpu_rdata", cpu_rdata, 0);
        check_val("rst_dbg_rdata", dbg_rdata, 0);
        check_val("rst_cpu_stall", cpu_stall, 0);
        rst        = 1'b0;
        last_dbg   = 1'b1;
        cpu_rd_exp = '0;
        dbg_rd_exp = '0;
    endtask

    // Plans the grant order and cycle timing from the arbitration rules, then
    // drives the requests and checks every cycle against that plan.
    task automatic run_round();
        txn_t order [$];
        int   issue_e [$];
        int   ack_e [$];
        int   ci;
        int   next_s;
        int   last_e;
        int   cpu_next;
        bit   dpend;
        bit   pick_dbg;
        bit   en_x, we_x, cack_x, dack_x, wd_chk;
        logic [ADDR_W-1:0] a_x;
        logic [31:0] d_x;
        int   w;

        ci     = 0;
        dpend  = has_dbg;
        next_s = 1;
        while (ci < ncpu || dpend) begin
            if (ci < ncpu && dpend) pick_dbg = !last_dbg;
            else                    pick_dbg = dpend;
            if (pick_dbg) begin
                order.push_back(dt);
                dpend = 1'b0;
            end else begin
                order.push_back(ct[ci]);
                ci++;
            end
            last_dbg = pick_dbg;
            issue_e.push_back(next_s);
            ack_e.push_back(next_s + (order[$].we ? 2 : 2 + LAT) - 1);
            next_s = ack_e[$] + 2;
        end
        last_e = ack_e[$] + 2;

        cpu_next  = 1;
        cpu_req   = (ncpu > 0);
        cpu_we    = ct[0].we;
        cpu_addr  = ct[0].addr;
        cpu_wdata = ct[0].wdata;
        dbg_req   = has_dbg;
        dbg_addr  = dt.addr[ADDR_W-1:0];

        for (int e = 1; e <= last_e; e++) begin
            en_x   = 1'b0;
            we_x   = 1'b0;
            cack_x = 1'b0;
            dack_x = 1'b0;
            wd_chk = 1'b0;
            a_x    = '0;
            d_x    = '0;
            @(posedge clk);
            @(negedge clk);
            for (int k = 0; k < order.size(); k++) begin
                if (issue_e[k] == e) begin
                    en_x   = 1'b1;
                    we_x   = order[k].we;
                    a_x    = ADDR_W'(word_of(order[k]));
                    d_x    = order[k].wdata;
                    wd_chk = order[k].we || order[k].is_dbg;
                end
                if (ack_e[k] == e) begin
                    w = word_of(order[k]);
                    if (order[k].is_dbg) dack_x = 1'b1;
                    else                 cack_x = 1'b1;
                    if (order[k].we) ref_mem[w] = order[k].wdata;
                    else if (order[k].is_dbg) dbg_rd_exp = ref_rd(w);
                    else cpu_rd_exp = ref_rd(w);
                end
            end
            check_val("mem_en", mem_en, en_x);
            check_val("mem_we", mem_we, we_x);
            if (en_x) check_val("mem_addr", mem_addr, a_x);
            if (wd_chk) check_val("mem_wdata", mem_wdata, d_x);
            check_val("cpu_ack", cpu_ack, cack_x);
            check_val("dbg_ack", dbg_ack, dack_x);
            check_val("cpu_stall", cpu_stall, cpu_req & ~cack_x);
            if (cack_x || dack_x) begin
                check_val("cpu_rdata", cpu_rdata, cpu_rd_exp);
                check_val("dbg_rdata", dbg_rdata, dbg_rd_exp);
            end
            if (drop_early && e == 1) begin
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
            if (cack_x) begin
                if (cpu_next < ncpu) begin
                    cpu_we    = ct[cpu_next].we;
                    cpu_addr  = ct[cpu_next].addr;
                    cpu_wdata = ct[cpu_next].wdata;
                    cpu_next++;
                end else begin
                    cpu_req = 1'b0;
                end
            end
            if (dack_x) dbg_req = 1'b0;
        end
    endtask

    task automatic lat3_txn(input bit we, input int w, input logic [31:0] wd,
                            input int exp_e, input logic [31:0] exp_rd);
        c3_req   = 1'b1;
        c3_we    = we;
        c3_addr  = 32'(w) << 2;
        c3_wdata = wd;
        for (int e = 1; e <= exp_e + 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("lat3_ack", c3_ack, (e == exp_e));
            check_val("lat3_stall", c3_stall, c3_req & ~(e == exp_e));
            check_val("lat3_dbg_ack", d3_ack, 0);
            if (e == exp_e) begin
                check_val("lat3_rdata", c3_rdata, exp_rd);
                c3_req = 1'b0;
            end
        end
    endtask

    task automatic set_round(input int nc, input bit hd, input bit de);
        ncpu       = nc;
        has_dbg    = hd;
        drop_early = de;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dbg_req   = 1'b0;
        dbg_addr  = '0;
        c3_req    = 1'b0;
        c3_we     = 1'b0;
        c3_addr   = '0;
        c3_wdata  = '0;
        d3_req    = 1'b0;
        d3_addr   = '0;
        dt        = mk_dbg(0);
        ct[0]     = mk_cpu(1'b0, 0, '0);
        ct[1]     = ct[0];

        do_reset();

        // Core write of 0xDEADBEEF to byte address 0x10, then read back.
        ct[0] = mk_cpu(1'b1, 4, 32'hDEAD_BEEF);
        ct[0].addr = 32'h0000_0010;
        set_round(1, 1'b0, 1'b0);
        run_round();
        ct[0] = mk_cpu(1'b0, 4, '0);
        set_round(1, 1'b0, 1'b0);
        run_round();

        // Inspection read of word 4 on its own.
        dt = mk_dbg(4);
        set_round(0, 1'b1, 1'b0);
        run_round();

        // Simultaneous requests after reset, then a second simultaneous pair.
        do_reset();
        ct[0] = mk_cpu(1'b0, 4, 32'h1234_5678);
        dt    = mk_dbg(5);
        set_round(1, 1'b1, 1'b0);
        run_round();
        ct[0] = mk_cpu(1'b1, 6, 32'h0BAD_F00D);
        dt    = mk_dbg(4);
        set_round(1, 1'b1, 1'b0);
        run_round();

        // Core requesting back to back while inspection waits.
        ct[0] = mk_cpu(1'b0, 6, '0);
        ct[1] = mk_cpu(1'b1, 7, 32'h5555_AAAA);
        dt    = mk_dbg(6);
        set_round(2, 1'b1, 1'b0);
        run_round();

        // Request withdrawn right after being sampled still completes.
        ct[0] = mk_cpu(1'b0, 7, '0);
        set_round(1, 1'b0, 1'b1);
        run_round();

        for (int r = 0; r < 120; r++) begin
            mode  = $urandom_range(0, 4);
            ct[0] = mk_cpu($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
            ct[1] = mk_cpu($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
            dt    = mk_dbg($urandom_range(0, 15));
            case (mode)
                0:       set_round(1, 1'b0, $urandom_range(0, 3) == 0);
                1:       set_round(0, 1'b1, $urandom_range(0, 3) == 0);
                2:       set_round(1, 1'b1, 1'b0);
                3:       set_round(2, 1'b1, 1'b0);
                default: set_round(2, 1'b0, 1'b0);
            endcase
            run_round();
        end

        // Reset while a core read sits in WAIT: the read is abandoned.
        ct[0] = mk_cpu(1'b0, 4, '0);
        set_round(1, 1'b0, 1'b0);
        run_round();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0014;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_val("wait_mem_en", mem_en, 0);
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_cpu_ack", cpu_ack, 0);
        check_val("midrst_dbg_ack", dbg_ack, 0);
        check_val("midrst_mem_en", mem_en, 0);
        check_val("midrst_cpu_rdata", cpu_rdata, 0);
        check_val("midrst_mem_addr", mem_addr, 0);
        rst        = 1'b0;
        last_dbg   = 1'b1;
        cpu_rd_exp = '0;
        dbg_rd_exp = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("abandoned_ack", cpu_ack, 0);
            check_val("abandoned_en", mem_en, 0);
        end

        // Three-cycle BRAM latency.
        lat3_txn(1'b1, 8, 32'hCAFE_F00D, 2, 32'h0);
        lat3_txn(1'b0, 8, 32'h0, 2 + LAT3, 32'hCAFE_F00D);
        lat3_txn(1'b0, 9, 32'h0, 2 + LAT3, init_val(9));
        check_val("lat3_dbg_rdata", d3_rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
